// File: rtl/miri_pkg.sv
// Shared decode constants: opcodes, opclass encoding and instruction field positions.
package miri_pkg;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JUMP   = 7'b1101111;

  typedef enum logic [2:0] {
    OPC_ALU_R   = 3'd0,
    OPC_ALU_I   = 3'd1,
    OPC_LOAD    = 3'd2,
    OPC_STORE   = 3'd3,
    OPC_BRANCH  = 3'd4,
    OPC_JUMP    = 3'd5,
    OPC_ILLEGAL = 3'd6
  } opclass_e;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  function automatic opclass_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_ALU_R:  return OPC_ALU_R;
      OP_ALU_I:  return OPC_ALU_I;
      OP_LOAD:   return OPC_LOAD;
      OP_STORE:  return OPC_STORE;
      OP_BRANCH: return OPC_BRANCH;
      OP_JUMP:   return OPC_JUMP;
      default:   return OPC_ILLEGAL;
    endcase
  endfunction

  // Only these classes actually consume rs2, so only they can hazard on it.
  function automatic logic uses_rs2(input opclass_e cls);
    return (cls == OPC_ALU_R) || (cls == OPC_STORE) || (cls == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports with writeback bypass, one write port.
module regfile #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] ra1,
  input  logic [IDX_W-1:0] ra2,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  input  logic             we,
  input  logic [IDX_W-1:0] wa,
  input  logic [XLEN-1:0]  wd
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // x0 is hardwired to zero; otherwise an in-flight write wins over stored contents.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (we && (wa == ra1)) rd1 = wd;
    if (we && (wa == ra2)) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split, immediate generation, register read, load-use hazard
// detection and the decode/execute pipeline register.
module decode_stage
  import miri_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] PCnext,
  input  logic            valid_in,
  input  logic            wrt_en,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [2:0]      opclass,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1_idx,
  output logic [4:0]      rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic            stall_fetch
);

  localparam int IDX_W = $clog2(NREGS);

  opclass_e               opclass_p0;
  logic [4:0]             rd_p0;
  logic [4:0]             rs1_p0;
  logic [4:0]             rs2_p0;
  logic [2:0]             funct3_p0;
  logic [6:0]             funct7_p0;
  logic [XLEN-1:0]        rs1_data_p0;
  logic [XLEN-1:0]        rs2_data_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic signed [11:0]     imm_i;
  logic signed [11:0]     imm_s;
  logic signed [12:0]     imm_b;
  logic signed [20:0]     imm_j;
  logic                   hazard;

  // Stage p0: combinational decode of the incoming instruction
  assign opclass_p0 = classify(instruction[OPCODE_MSB:OPCODE_LSB]);
  assign rd_p0      = instruction[RD_MSB:RD_LSB];
  assign funct3_p0  = instruction[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1_p0     = instruction[RS1_MSB:RS1_LSB];
  assign rs2_p0     = instruction[RS2_MSB:RS2_LSB];
  assign funct7_p0  = instruction[FUNCT7_MSB:FUNCT7_LSB];

  assign imm_i = instruction[31:20];
  assign imm_s = {instruction[31:25], instruction[11:7]};
  assign imm_b = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    imm_p0 = '0;
    case (opclass_p0)
      OPC_ALU_I, OPC_LOAD: imm_p0 = XLEN'(imm_i);
      OPC_STORE:           imm_p0 = XLEN'(imm_s);
      OPC_BRANCH:          imm_p0 = XLEN'(imm_b);
      OPC_JUMP:            imm_p0 = XLEN'(imm_j);
      default:             imm_p0 = '0;
    endcase
  end

  regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1_p0[IDX_W-1:0]),
    .ra2   (rs2_p0[IDX_W-1:0]),
    .rd1   (rs1_data_p0),
    .rd2   (rs2_data_p0),
    .we    (wb_en),
    .wa    (wb_rd[IDX_W-1:0]),
    .wd    (wb_data)
  );

  // A load still in the output register whose result the incoming instruction needs.
  assign hazard = valid_in && valid_out && (opclass == 3'(OPC_LOAD)) && (rd != '0) &&
                  ((rd == rs1_p0) || (uses_rs2(opclass_p0) && (rd == rs2_p0)));

  assign stall_fetch = hazard && !flush && wrt_en && !reset;

  // Stage p1: decode/execute pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      pc_out    <= '0;
      opclass   <= '0;
      funct3    <= '0;
      funct7    <= '0;
      rd        <= '0;
      rs1_idx   <= '0;
      rs2_idx   <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      imm       <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (!wrt_en) begin
      valid_out <= valid_out;
    end else if (stall_fetch) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      pc_out    <= PCnext;
      opclass   <= opclass_p0;
      funct3    <= funct3_p0;
      funct7    <= funct7_p0;
      rd        <= rd_p0;
      rs1_idx   <= rs1_p0;
      rs2_idx   <= rs2_p0;
      rs1_data  <= rs1_data_p0;
      rs2_data  <= rs2_data_p0;
      imm       <= imm_p0;
    end
  end

endmodule
